// File: rtl/tick_timer_pkg.sv
// Shared types and default constants for the tick timer scheduler and its prescaler.
package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RUN  = 2'd2
  } ch_state_t;

  localparam int CLK_DIV_DEFAULT = 50000;
  localparam int CNT_W_DEFAULT   = 16;
  localparam int NUM_CH_DEFAULT  = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick divider: one-cycle registered tick every DIV clk cycles, first tick DIV cycles after clr.
module tick_prescaler
  import tick_timer_pkg::*;
#(
  parameter int DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_timer_sched.sv
// Shared countdown-timer service: prescaler, round-robin load arbiter and NUM_CH channel FSMs.
// Optional periodic auto-reload is enabled by defining TICK_TIMER_AUTORELOAD_EN.
module tick_timer_sched
  import tick_timer_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int NUM_CH  = NUM_CH_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  output logic [NUM_CH-1:0]       ack,
  input  logic [NUM_CH-1:0]       cancel,
`ifdef TICK_TIMER_AUTORELOAD_EN
  input  logic [NUM_CH-1:0]       periodic,
`endif
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       expire,
  output logic                    tick
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  gidx;
  logic              found;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] grant;

  tick_prescaler #(.DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  // First eligible channel at or after the pointer wins this cycle.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] cand;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = PTR_W'(idx);
      if (!found && elig[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gidx        = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gidx == PTR_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t        st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] ld;
    logic             ack_q, ack_nxt, exp_q, exp_nxt, busy_q;
`ifdef TICK_TIMER_AUTORELOAD_EN
    logic [CNT_W-1:0] rld, rld_nxt;
`endif

    assign ld = load_val[i*CNT_W +: CNT_W];

    // A running channel with req high is a retrigger; the ack cycle is masked
    // because the requester still holds req while it sees ack.
    assign elig[i] = req[i] & ~cancel[i] & ~ack_q & ((st == PEND) | (st == RUN));

    always_comb begin
      st_nxt  = st;
      cnt_nxt = cnt;
      ack_nxt = 1'b0;
      exp_nxt = 1'b0;
`ifdef TICK_TIMER_AUTORELOAD_EN
      rld_nxt = rld;
`endif
      if (cancel[i]) begin
        st_nxt = IDLE;
      end else if (grant[i]) begin
        st_nxt  = RUN;
        cnt_nxt = ld;
        ack_nxt = 1'b1;
`ifdef TICK_TIMER_AUTORELOAD_EN
        rld_nxt = ld;
`endif
      end else begin
        case (st)
          IDLE: if (req[i]) st_nxt = PEND;
          PEND: if (!req[i]) st_nxt = IDLE;
          RUN: begin
            if ((cnt == '0) || (tick && (cnt == CNT_W'(1)))) begin
              exp_nxt = 1'b1;
`ifdef TICK_TIMER_AUTORELOAD_EN
              if (periodic[i]) begin
                cnt_nxt = (rld == '0) ? CNT_W'(1) : rld;
              end else begin
                st_nxt  = IDLE;
                cnt_nxt = '0;
              end
`else
              st_nxt  = IDLE;
              cnt_nxt = '0;
`endif
            end else if (tick) begin
              cnt_nxt = cnt - 1'b1;
            end
          end
          default: st_nxt = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        st     <= IDLE;
        cnt    <= '0;
        ack_q  <= 1'b0;
        exp_q  <= 1'b0;
        busy_q <= 1'b0;
`ifdef TICK_TIMER_AUTORELOAD_EN
        rld    <= '0;
`endif
      end else begin
        st     <= st_nxt;
        cnt    <= cnt_nxt;
        ack_q  <= ack_nxt;
        exp_q  <= exp_nxt;
        busy_q <= (st_nxt != IDLE);
`ifdef TICK_TIMER_AUTORELOAD_EN
        rld    <= rld_nxt;
`endif
      end
    end

    assign ack[i]    = ack_q;
    assign expire[i] = exp_q;
    assign busy[i]   = busy_q;
  end

endmodule

// File: tb/tb_tick_timer_sched.sv
// Directed scoreboard bench for tick_timer_sched with CLK_DIV=4, NUM_CH=4, CNT_W=8.
module tb_tick_timer_sched;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DIV = 4;

  logic           clk = 1'b0;
  logic           clr;
  logic [NCH-1:0] req;
  logic [NCH*CW-1:0] load_val;
  logic [NCH-1:0] ack;
  logic [NCH-1:0] cancel;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] expire;
  logic           tick;
`ifdef TICK_TIMER_AUTORELOAD_EN
  logic [NCH-1:0] periodic;
`endif

  tick_timer_sched #(.CLK_DIV(DIV), .NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .load_val (load_val),
    .ack      (ack),
    .cancel   (cancel),
`ifdef TICK_TIMER_AUTORELOAD_EN
    .periodic (periodic),
`endif
    .busy     (busy),
    .expire   (expire),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 0 = ack, 1 = expire
    int ch;
    int at;
    bit keep;   // busy stays high at this expire
  } ev_t;

  ev_t sb[$];
  int  cyc;
  int  cmp_cnt;
  int  err_cnt;
  int  ptr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Sample index of the expire pulse for a channel loaded with l at grant sample g.
  function automatic int exp_at(input int g, input int l);
    int n0;
    if (l == 0) return g + 1;
    n0 = ((g + DIV - 1) / DIV) * DIV;
    return n0 + DIV * (l - 1) + 1;
  endfunction

  task automatic push(input int kind, input int ch, input int at, input bit keep);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    e.at   = at;
    e.keep = keep;
    sb.push_back(e);
  endtask

  task automatic drop(input int ch);
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].ch == ch) sb.delete(k);
  endtask

  // Uncontended request: grant lands two samples later.
  task automatic issue(input int ch, input int l, input int periods);
    int g, e;
    req[ch] = 1'b1;
    load_val[ch*CW +: CW] = CW'(l);
    g = cyc + 2;
    e = exp_at(g, l);
    push(0, ch, g, 1'b0);
    if (periods == 0) push(1, ch, e, 1'b0);
    else for (int k = 0; k < periods; k++) push(1, ch, e + k * DIV * l, 1'b1);
    ptr_m = (ch + 1) % NCH;
  endtask

  // All channels request together; grants follow the model pointer order.
  task automatic issue_all(input int l);
    int ch, g;
    for (int k = 0; k < NCH; k++) begin
      ch = (ptr_m + k) % NCH;
      g  = cyc + 2 + k;
      req[ch] = 1'b1;
      load_val[ch*CW +: CW] = CW'(l);
      push(0, ch, g, 1'b0);
      push(1, ch, exp_at(g, l), 1'b0);
    end
  endtask

  task automatic step();
    logic [NCH-1:0] ea, ee, bm, bv;
    @(posedge clk);
    #1;
    cyc++;
    ea = '0; ee = '0; bm = '0; bv = '0;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].at <= cyc) begin
        if (sb[k].kind == 0) ea[sb[k].ch] = 1'b1;
        else begin
          ee[sb[k].ch] = 1'b1;
          bm[sb[k].ch] = 1'b1;
          bv[sb[k].ch] = sb[k].keep;
        end
        sb.delete(k);
      end
    end
    chk("tick", 32'(tick), 32'((cyc % DIV) == 0));
    chk("ack", 32'(ack), 32'(ea));
    chk("expire", 32'(expire), 32'(ee));
    if (bm != '0) chk("busy_at_expire", 32'(busy & bm), 32'(bv));
    req = req & ~ack;
  endtask

  initial begin
    int last;
    clr = 1'b1; req = '0; cancel = '0; load_val = '0;
    cyc = 0; cmp_cnt = 0; err_cnt = 0; ptr_m = 0;
`ifdef TICK_TIMER_AUTORELOAD_EN
    periodic = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_expire", 32'(expire), 32'd0);
    #4 clr = 1'b0;
    cyc = 0;
    repeat (3) step();

    // single timer
    issue(0, 3, 0);
    step(); step();
    chk("busy0_after_ack", 32'(busy[0]), 32'd1);
    repeat (20) step();

    // arbitration from pointer 0, then from pointer 2
    issue_all(2);
    repeat (20) step();
    issue(1, 1, 0);
    repeat (12) step();
    issue_all(2);
    repeat (20) step();

    // edge loads
    issue(1, 0, 0);
    repeat (5) step();
    issue(0, 255, 0);
    repeat (1030) step();

    // cancel while running
    issue(2, 10, 0);
    repeat (5) step();
    cancel[2] = 1'b1;
    drop(2);
    step();
    chk("busy2_after_cancel", 32'(busy[2]), 32'd0);
    cancel = '0;
    repeat (50) step();

    // cancel coincident with grant: ch2 loses, ch3 granted instead
    req[2] = 1'b1; req[3] = 1'b1;
    load_val[2*CW +: CW] = 8'd3;
    load_val[3*CW +: CW] = 8'd3;
    push(0, 3, cyc + 2, 1'b0);
    push(1, 3, exp_at(cyc + 2, 3), 1'b0);
    ptr_m = 0;
    step();
    cancel[2] = 1'b1;
    step();
    chk("busy2_cancel_at_grant", 32'(busy[2]), 32'd0);
    cancel = '0;
    req[2] = 1'b0;
    repeat (20) step();

    // clr in the middle of a running count
    issue(1, 5, 0);
    repeat (8) step();
    #2 clr = 1'b1;
    #1;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_ack", 32'(ack), 32'd0);
    chk("clr_expire", 32'(expire), 32'd0);
    chk("clr_tick", 32'(tick), 32'd0);
    sb.delete();
    req = '0;
    ptr_m = 0;
    repeat (2) @(posedge clk);
    #5 clr = 1'b0;
    cyc = 0;
    repeat (30) step();

`ifdef TICK_TIMER_AUTORELOAD_EN
    periodic[3] = 1'b1;
    issue(3, 2, 5);
    last = exp_at(cyc + 2, 2) + 4 * DIV * 2;
    while (cyc < last) step();
    cancel[3] = 1'b1;
    drop(3);
    step();
    chk("busy3_periodic_cancel", 32'(busy[3]), 32'd0);
    cancel = '0;
    periodic = '0;
    repeat (20) step();
`else
    last = 0;
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/tick_timer_sched.md
Name: tick_timer_sched

Overview:
Shared timeout service for the vending controller: coin-insert timeout, dispense-motor on-time, display blink, and similar timers. It owns a base-tick prescaler (1 kHz enable from the 50 MHz board clock) and NUM_CH countdown channels. Requesters submit timer loads through a req/ack handshake. A round-robin arbiter grants at most one load per clk cycle. Each running channel decrements on every base tick and pulses expire on reaching zero.

Parameters:
CLK_DIV, 50000, clk cycles per base tick; must be >= 2
NUM_CH, 4, number of timer channels/requesters
CNT_W, 16, countdown width in ticks

Ports:
clk  in  1  system clock
clr  in  1  reset, asynchronous, active-high
req  in  NUM_CH  per-channel load request; held high until ack
load_val  in  NUM_CH*CNT_W  per-channel duration in ticks; channel i occupies bits [i*CNT_W +: CNT_W]
ack  out  NUM_CH  one-cycle grant pulse, at most one bit set
cancel  in  NUM_CH  stop channel immediately
busy  out  NUM_CH  channel pending or running
expire  out  NUM_CH  one-cycle pulse when the channel reaches zero
tick  out  1  one-cycle base-tick pulse, exported for other blocks

Behaviour:
Reset (clr high):
- prescaler = 0; all counters = 0; all channels IDLE; round-robin pointer = 0.
- tick = 0, ack = 0, busy = 0, expire = 0.
- clr mid-operation aborts every channel with no expire pulse.

Prescaler:
- Counts 0..CLK_DIV-1 and wraps.
- tick is registered high for exactly one cycle when the count wraps from CLK_DIV-1 to 0.
- First tick occurs CLK_DIV cycles after clr deasserts.

Per-channel FSM (registered), states IDLE, PEND, RUN:
- IDLE -> PEND when req[i]=1.
- PEND -> RUN on grant. The registered ack[i]=1 in the following cycle. The counter is loaded with load_val[i] in the same edge.
- RUN: counter decrements by 1 on each tick.
  - At a tick with counter==1: go to IDLE; expire[i]=1 the next cycle.
  - Counter loaded with 0: expire the cycle after ack, then IDLE. No tick is required.
- A tick coinciding with the load edge does not decrement the new value.
- Counter never underflows; the arithmetic is unsigned CNT_W.

Arbitration:
- Round-robin among channels in PEND.
- Search starts at the pointer. After a grant, the pointer = granted index + 1 mod NUM_CH.
- A requester waits at most NUM_CH-1 cycles.

Handshake:
- Requesters hold req and load_val stable until ack.
- Deasserting req before ack returns the channel to IDLE (withdrawal).
- req high while the channel is RUN is a retrigger: it re-enters arbitration while the old count keeps running, and the grant overwrites the count.

Cancel:
- cancel[i] has highest priority: the channel goes to IDLE next edge.
- No expire pulse, and no ack if granted in the same cycle; the arbiter skips that channel this cycle.

busy[i] = (state != IDLE), registered.

Optional Feature:
Macro: TICK_TIMER_AUTORELOAD_EN.
- Defined:
  - Adds input periodic (NUM_CH) and an internal reload register per channel, captured at grant.
  - At expiry with periodic[i]=1, the channel stays in RUN and the counter reloads from the reload register on the same edge. expire still pulses every period.
  - A reload value of 0 is treated as 1, so a periodic channel never expires every cycle.
  - cancel stops the channel.
- Undefined: the port and registers are absent; every channel is one-shot.

Decomposition:
- Package tick_timer_pkg holds:
  - the channel state encoding (IDLE=2'd0, PEND=2'd1, RUN=2'd2);
  - the default constants CLK_DIV_DEFAULT=50000, CNT_W_DEFAULT=16.
- Sub-module tick_prescaler(clk, clr, tick), parameter DIV: the base-tick divider, reusable by the display scan logic.
- The arbiter and channel FSMs stay in the top module, in a generate loop.

Test Plan:
All scenarios use CLK_DIV=4, NUM_CH=4, CNT_W=8.
- Reset: assert clr mid-count with channel 1 RUN at 5 -> all outputs 0 immediately, no expire; first tick 4 cycles after release.
- Single timer: req[0] with load_val=3 -> ack[0] one cycle; busy[0]=1; expire[0] pulses after exactly 3 ticks (12 cycles ±3 phase); busy drops the same cycle.
- Arbitration: req on all 4 channels in the same cycle -> acks on channels 0, 1, 2, 3 in consecutive cycles. Repeat with the pointer at 2 -> order 2, 3, 0, 1.
- Edge values: load 0 -> expire the cycle after ack. Load 255 -> expire after 255 ticks, no wrap.
- Cancel: cancel[2] during RUN -> busy[2]=0 next cycle, no expire. cancel coincident with grant -> no ack, and the grant goes to the next PEND channel.
- Autoreload (macro defined): periodic[3]=1, load 2 -> expire[3] every 2 ticks for 5 periods; cancel stops it.
